// File: rtl/reg_scoreboard_if.sv
// ----------------------------------------------------------------------------
// reg_scoreboard_if
//   Bundle between the decode/writeback pipeline and the register scoreboard.
//
//   master (pipeline side) drives:
//     issue_valid, issue_wb_en, issue_dest  - instruction presented at decode
//     src1, src2, src1_used, src2_used      - its source operands
//     wb_valid, wb_dest                     - register-file write this cycle
//   slave (scoreboard side) drives:
//     stall, busy1, busy2                   - combinational hazard status
//     pending_total                         - registered sum of pending writes
//     err_underflow                         - sticky writeback-underflow flag
// ----------------------------------------------------------------------------
interface reg_scoreboard_if;
    logic       issue_valid;
    logic       issue_wb_en;
    logic [4:0] issue_dest;
    logic [4:0] src1;
    logic [4:0] src2;
    logic       src1_used;
    logic       src2_used;
    logic       wb_valid;
    logic [4:0] wb_dest;

    logic       stall;
    logic       busy1;
    logic       busy2;
    logic [6:0] pending_total;
    logic       err_underflow;

    modport master (
        output issue_valid, issue_wb_en, issue_dest,
        output src1, src2, src1_used, src2_used,
        output wb_valid, wb_dest,
        input  stall, busy1, busy2, pending_total, err_underflow
    );

    modport slave (
        input  issue_valid, issue_wb_en, issue_dest,
        input  src1, src2, src1_used, src2_used,
        input  wb_valid, wb_dest,
        output stall, busy1, busy2, pending_total, err_underflow
    );
endinterface

// File: rtl/reg_scoreboard.sv
// ----------------------------------------------------------------------------
// reg_scoreboard
//   Per-register pending-write counters for an in-order issue pipeline.
//   Each architectural register 1..31 counts the writes issued to it that
//   have not yet written back; register 0 is hardwired and never busy.
//   A source with a non-zero count is busy; a destination whose count is
//   saturated stalls issue so that no counter can wrap.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous, active-high reset; clears all pending state
//   sb   - reg_scoreboard_if.slave (issue, writeback and status signals)
//
// Parameters:
//   CNT_W - counter width; up to 2**CNT_W-1 writes in flight per register
// ----------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    reg_scoreboard_if.slave  sb
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Entry 0 exists only so the array can be indexed directly by a 5-bit
    // register number; it is held at zero and folds away in synthesis.
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [6:0]       total_q, total_d;
    logic             err_q, err_d;

    logic busy1, busy2, dest_full, stall;
    logic inc_en, dec_en, underflow;

    // NOTE: every signal assigned in always_comb gets a default value first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        // No writeback bypass: the register file writes on the edge, so a
        // same-cycle read still sees the old value and must still wait.
        busy1     = (sb.src1 != 5'd0) && (cnt_q[sb.src1] != '0);
        busy2     = (sb.src2 != 5'd0) && (cnt_q[sb.src2] != '0);
        dest_full = sb.issue_wb_en && (sb.issue_dest != 5'd0)
                    && (cnt_q[sb.issue_dest] == CNT_MAX);
        stall     = sb.issue_valid && ((sb.src1_used && busy1) ||
                                       (sb.src2_used && busy2) ||
                                       dest_full);

        inc_en    = sb.issue_valid && !stall && sb.issue_wb_en
                    && (sb.issue_dest != 5'd0);
        dec_en    = sb.wb_valid && (sb.wb_dest != 5'd0)
                    && (cnt_q[sb.wb_dest] != '0);
        underflow = sb.wb_valid && (sb.wb_dest != 5'd0)
                    && (cnt_q[sb.wb_dest] == '0);

        cnt_d[0] = '0;
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            // Increment and decrement of the same register cancel out.
            if (inc_en && (sb.issue_dest == 5'(r)) &&
                !(dec_en && (sb.wb_dest == 5'(r))))
                cnt_d[r] = cnt_q[r] + 1'b1;
            else if (dec_en && (sb.wb_dest == 5'(r)) &&
                     !(inc_en && (sb.issue_dest == 5'(r))))
                cnt_d[r] = cnt_q[r] - 1'b1;
        end

        // Summed from the next-state counters so the registered total
        // matches the counters after the same edge.
        total_d = '0;
        for (int r = 1; r < 32; r++)
            total_d = total_d + 7'(cnt_d[r]);

        err_d = err_q || underflow;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter array is reset deliberately; an in-flight
            // write from before reset must never keep a register busy.
            for (int r = 0; r < 32; r++)
                cnt_q[r] <= '0;
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++)
                cnt_q[r] <= cnt_d[r];
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    assign sb.stall         = stall;
    assign sb.busy1         = busy1;
    assign sb.busy2         = busy2;
    assign sb.pending_total = total_q;
    assign sb.err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_reg_scoreboard
//   Directed bench for reg_scoreboard (CNT_W = 2). A table of per-cycle
//   vectors walks the scoreboard through its normal hazards; hand-written
//   sequences cover asynchronous reset between edges and post-reset
//   writebacks.
// ----------------------------------------------------------------------------
module tb_reg_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    reg_scoreboard_if sb_if ();

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if.slave)
    );

    typedef struct {
        string      name;
        logic       iv;
        logic       wen;
        logic [4:0] dest;
        logic [4:0] s1;
        logic       s1u;
        logic [4:0] s2;
        logic       s2u;
        logic       wv;
        logic [4:0] wd;
        logic       e_stall;
        logic       e_b1;
        logic       e_b2;
        logic [6:0] e_total;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic wen, input logic [4:0] dest,
                         input logic [4:0] s1, input logic s1u,
                         input logic [4:0] s2, input logic s2u,
                         input logic wv, input logic [4:0] wd);
        sb_if.issue_valid = iv;
        sb_if.issue_wb_en = wen;
        sb_if.issue_dest  = dest;
        sb_if.src1        = s1;
        sb_if.src1_used   = s1u;
        sb_if.src2        = s2;
        sb_if.src2_used   = s2u;
        sb_if.wb_valid    = wv;
        sb_if.wb_dest     = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        // name, iv wen dest, s1 s1u, s2 s2u, wv wd, stall b1 b2, total err
        vecs.push_back('{"idle",          0,0,5'd0,  5'd0,0, 5'd0,0, 0,5'd0,  0,0,0, 7'd0, 0});
        vecs.push_back('{"issue_d5",      1,1,5'd5,  5'd0,0, 5'd0,0, 0,5'd0,  0,0,0, 7'd1, 0});
        vecs.push_back('{"raw_s1_5",      1,1,5'd6,  5'd5,1, 5'd0,0, 0,5'd0,  1,1,0, 7'd1, 0});
        vecs.push_back('{"raw_wb_same",   1,1,5'd6,  5'd5,1, 5'd0,0, 1,5'd5,  1,1,0, 7'd0, 0});
        vecs.push_back('{"raw_released",  1,1,5'd6,  5'd5,1, 5'd0,0, 0,5'd0,  0,0,0, 7'd1, 0});
        vecs.push_back('{"wb_d6",         0,0,5'd0,  5'd0,0, 5'd0,0, 1,5'd6,  0,0,0, 7'd0, 0});
        vecs.push_back('{"issue_d0",      1,1,5'd0,  5'd0,0, 5'd0,0, 0,5'd0,  0,0,0, 7'd0, 0});
        vecs.push_back('{"read_r0",       1,0,5'd0,  5'd0,1, 5'd0,1, 0,5'd0,  0,0,0, 7'd0, 0});
        vecs.push_back('{"d7_first",      1,1,5'd7,  5'd0,0, 5'd0,0, 0,5'd0,  0,0,0, 7'd1, 0});
        vecs.push_back('{"d7_waw2",       1,1,5'd7,  5'd0,0, 5'd0,0, 0,5'd0,  0,0,0, 7'd2, 0});
        vecs.push_back('{"d7_waw3",       1,1,5'd7,  5'd0,0, 5'd0,0, 0,5'd0,  0,0,0, 7'd3, 0});
        vecs.push_back('{"d7_full",       1,1,5'd7,  5'd0,0, 5'd0,0, 0,5'd0,  1,0,0, 7'd3, 0});
        vecs.push_back('{"invalid_issue", 0,1,5'd7,  5'd7,1, 5'd7,1, 0,5'd0,  0,1,1, 7'd3, 0});
        vecs.push_back('{"s2_unused",     1,1,5'd8,  5'd3,1, 5'd7,0, 0,5'd0,  0,0,1, 7'd4, 0});
        vecs.push_back('{"inc9_dec7",     1,1,5'd9,  5'd0,0, 5'd0,0, 1,5'd7,  0,0,0, 7'd4, 0});
        vecs.push_back('{"inc_dec_9",     1,1,5'd9,  5'd9,0, 5'd0,0, 1,5'd9,  0,1,0, 7'd4, 0});
        vecs.push_back('{"wb_d0",         0,0,5'd0,  5'd0,0, 5'd0,0, 1,5'd0,  0,0,0, 7'd4, 0});
        vecs.push_back('{"underflow_12",  0,0,5'd0,  5'd0,0, 5'd0,0, 1,5'd12, 0,0,0, 7'd4, 1});
        vecs.push_back('{"err_sticky",    0,0,5'd0,  5'd8,1, 5'd9,1, 0,5'd0,  0,1,1, 7'd4, 1});

        // Reset state, held with rst asserted.
        idle();
        #2;
        check("rst_total", 32'(sb_if.pending_total), 32'd0);
        check("rst_err",   32'(sb_if.err_underflow), 32'd0);
        check("rst_stall", 32'(sb_if.stall),         32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table: inputs applied on the falling edge, combinational outputs
        // checked before the rising edge, registered outputs just after it.
        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].wen, vecs[i].dest, vecs[i].s1, vecs[i].s1u,
                  vecs[i].s2, vecs[i].s2u, vecs[i].wv, vecs[i].wd);
            #1;
            check({vecs[i].name, ".stall"}, 32'(sb_if.stall), 32'(vecs[i].e_stall));
            check({vecs[i].name, ".busy1"}, 32'(sb_if.busy1), 32'(vecs[i].e_b1));
            check({vecs[i].name, ".busy2"}, 32'(sb_if.busy2), 32'(vecs[i].e_b2));
            @(posedge clk);
            #1;
            check({vecs[i].name, ".total"}, 32'(sb_if.pending_total), 32'(vecs[i].e_total));
            check({vecs[i].name, ".err"},   32'(sb_if.err_underflow), 32'(vecs[i].e_err));
            @(negedge clk);
        end

        // Asynchronous reset between edges with four writes pending
        // (r7=2, r8=1, r9=1): outputs clear before any clock edge.
        drive(1'b1, 1'b0, 5'd0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0);
        #1;
        check("pre_rst.total", 32'(sb_if.pending_total), 32'd4);
        check("pre_rst.stall", 32'(sb_if.stall),         32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst.total", 32'(sb_if.pending_total), 32'd0);
        check("async_rst.stall", 32'(sb_if.stall),         32'd0);
        check("async_rst.busy1", 32'(sb_if.busy1),         32'd0);
        check("async_rst.busy2", 32'(sb_if.busy2),         32'd0);
        check("async_rst.err",   32'(sb_if.err_underflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // First edge after release: a stale writeback to r7 is an underflow,
        // while a new issue to r3 counts normally.
        drive(1'b1, 1'b1, 5'd3, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7);
        #1;
        check("post_rst.stall", 32'(sb_if.stall), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst.total", 32'(sb_if.pending_total), 32'd1);
        check("post_rst.err",   32'(sb_if.err_underflow), 32'd1);
        @(negedge clk);

        // Read r3 while its write is pending, then retire it.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd3);
        #1;
        check("r3_busy2", 32'(sb_if.busy2), 32'd1);
        check("r3_stall", 32'(sb_if.stall), 32'd1);
        @(posedge clk);
        #1;
        check("r3_retired.total", 32'(sb_if.pending_total), 32'd0);
        @(negedge clk);
        idle();
        #1;
        check("r3_free.busy2", 32'(sb_if.busy2), 32'd0);

        // err_underflow clears only on reset.
        rst = 1'b1;
        #1;
        check("err_cleared", 32'(sb_if.err_underflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2: width of each per-register pending-write counter; maximum in-flight writes per register is 2^CNT_W-1.
REQ-002 SHALL have clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have issue_valid, input, 1 bit: decode stage presents an instruction this cycle.
REQ-005 SHALL have issue_wb_en, input, 1 bit: the presented instruction will write a register.
REQ-006 SHALL have issue_dest, input, 5 bits: destination register of the presented instruction.
REQ-007 SHALL have src1 and src2, inputs, 5 bits each: source registers of the presented instruction.
REQ-008 SHALL have src1_used and src2_used, inputs, 1 bit each: the corresponding source is actually read.
REQ-009 SHALL have wb_valid, input, 1 bit: a register-file write occurs this cycle; same timing as the register-file write enable.
REQ-010 SHALL have wb_dest, input, 5 bits: register being written back.
REQ-011 SHALL have stall, output, 1 bit: combinational; the presented instruction must be held.
REQ-012 SHALL have busy1 and busy2, outputs, 1 bit each: combinational; src1 or src2 has a pending write.
REQ-013 SHALL have pending_total, output, 7 bits: registered sum of all counters.
REQ-014 SHALL have err_underflow, output, 1 bit: sticky flag; writeback with no pending write.

Function
REQ-015 SHALL keep one CNT_W-bit counter cnt[r] for each register r = 1..31; register 0 has no counter and is never busy.
REQ-016 SHALL compute busyN = (srcN != 0) & (cnt[srcN] != 0), with no same-cycle writeback bypass: the register file writes on the edge, so a same-cycle read still returns the old value.
REQ-017 SHALL assert stall = issue_valid & ((src1_used & busy1) | (src2_used & busy2) | (issue_wb_en & issue_dest != 0 & cnt[issue_dest] == max)).
REQ-018 SHALL accept an issue when issue_valid & !stall; an accepted issue with issue_wb_en and issue_dest != 0 increments cnt[issue_dest] at the next edge.
REQ-019 SHALL allow a write-after-write issue to a busy destination, provided the counter is not at max.
REQ-020 SHALL decrement cnt[wb_dest] at the next edge when wb_valid, wb_dest != 0 and cnt[wb_dest] != 0.
REQ-021 SHALL set err_underflow at the next edge when wb_valid, wb_dest != 0 and cnt[wb_dest] == 0; the counter stays 0.
REQ-022 SHALL leave the counter unchanged when an accepted increment and a decrement target the same register in the same cycle.
REQ-023 SHALL handle an increment on one register and a decrement on another register in the same cycle independently.
REQ-024 SHALL ignore issues and writebacks with dest 0: no counter change and no error.
REQ-025 SHALL ignore issue_wb_en, issue_dest, src1, src2, src1_used and src2_used when issue_valid is 0.
REQ-026 SHALL update pending_total at the same edge as the counters, so it equals the sum of the post-update counters.
REQ-027 SHALL never wrap any counter: no increment at max (stall prevents it) and no decrement at 0.
REQ-028 SHALL keep err_underflow set until reset.

Reset
REQ-029 SHALL, on rst, clear all counters, pending_total and err_underflow immediately (asynchronously), so that stall, busy1 and busy2 read 0.
REQ-030 SHALL, on reset mid-operation, discard all pending state; writebacks arriving after reset release are underflows.
REQ-031 SHALL resume normal updates at the first rising edge after rst deasserts.

Verification
REQ-032 Issue dest=5 with wb_en, then the next cycle issue with src1=5, src1_used=1 -> stall=1 and busy1=1 until wb_valid with wb_dest=5; stall=0 in the cycle after that writeback edge.
REQ-033 Issue dest=0 with wb_en, then read src1=0 -> busy1=0, stall=0, pending_total=0.
REQ-034 Three accepted issues to dest=7 (CNT_W=2) -> cnt=3 and pending_total=3; a fourth issue to dest=7 with no sources used -> stall=1 with the counter held at 3.
REQ-035 cnt[9]=1, then an issue to dest 9 and wb_valid to 9 in the same cycle -> cnt[9] stays 1 and pending_total is unchanged.
REQ-036 wb_valid with wb_dest=12 while cnt[12]=0 -> err_underflow=1 at the next edge and held; pulse rst -> err_underflow=0.
REQ-037 Assert rst asynchronously between edges with pending_total=4 -> pending_total=0 and stall=0 immediately, without waiting for a clock edge.
